spinner_quad_decoder: RTL and testbench

- Receive side of the spinner AB quadrature interface. Consumes the 2-bit spinner phase pair that the spinner emulator or the USER_IN encoder produces, and decodes it into counts the game logic can read.
- Stages: synchroniser, glitch filter, quadrature decoder, wrapping absolute position, and a saturating delta-since-last-read register for the CPU/MCU side.
- Runs in the clk_12m domain inside the arkanoid core.

---
 rtl/spinner_quad_decoder_if.sv | 24 ++
 rtl/spinner_quad_decoder.sv | 139 +++++++++++++
 tb/tb_spinner_quad_decoder.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spinner_quad_decoder_if.sv
// Spinner decoder bus: sample enable, raw phases, CPU strobes, decoded outputs.
// master drives ce/spinner/clear/rd; slave (the decoder) drives the rest.
interface spinner_quad_decoder_if;
  logic       ce;
  logic [1:0] spinner;
  logic       clear;
  logic       rd;
  logic [7:0] rd_data;
  logic [7:0] position;
  logic       step;
  logic       dir;
  logic       err;
  logic [3:0] err_cnt;

  modport master (
    output ce, spinner, clear, rd,
    input  rd_data, position, step, dir, err, err_cnt
  );

  modport slave (
    input  ce, spinner, clear, rd,
    output rd_data, position, step, dir, err, err_cnt
  );
endinterface

// File: rtl/spinner_quad_decoder.sv
// Spinner AB quadrature receiver: sync, glitch filter, decode, position, delta.
// Ports: clk_12m, reset (async low), bus (slave: ce/spinner/clear/rd in; rd_data/position/step/dir/err/err_cnt out).
module spinner_quad_decoder #(
  parameter int SYNC_STAGES     = 2,
  parameter int FILTER_LEN      = 4,
  parameter int EDGES_PER_COUNT = 1
) (
  input  logic                   clk_12m,
  input  logic                   reset,
  spinner_quad_decoder_if.slave  bus
);

  localparam logic [3:0] FL_M1 = 4'(FILTER_LEN - 1);
  localparam logic signed [3:0] EPC = 4'(EDGES_PER_COUNT);
  localparam logic signed [3:0] EMC = -EPC;

  logic [SYNC_STAGES-1:0][1:0] r_sync;
  logic [1:0]        r_cand;
  logic [1:0]        r_filt;
  logic [1:0]        r_prev;
  logic [3:0]        r_fcnt;
  logic signed [3:0] r_acc;
  logic [7:0]        r_pos;
  logic signed [7:0] r_delta;
  logic [7:0]        r_rd_data;
  logic              r_step;
  logic              r_dir;
  logic              r_err;
  logic [3:0]        r_err_cnt;

  logic [1:0]        w_sync;
  logic [1:0]        w_pi;
  logic [1:0]        w_ni;
  logic [1:0]        w_d;
  logic              w_chg;
  logic              w_fwd;
  logic              w_rev;
  logic              w_ill;
  logic signed [3:0] w_acc_nx;
  logic              w_emit_p;
  logic              w_emit_n;
  logic              w_emit;

  assign w_sync = r_sync[SYNC_STAGES-1];

  // Gray position: 00->0, 10->1, 11->2, 01->3
  assign w_pi = {r_prev[0], r_prev[1] ^ r_prev[0]};
  assign w_ni = {r_filt[0], r_filt[1] ^ r_filt[0]};
  assign w_d  = w_ni - w_pi;

  assign w_chg = bus.ce && (r_prev != r_filt);
  assign w_fwd = w_chg && (w_d == 2'd1);
  assign w_rev = w_chg && (w_d == 2'd3);
  assign w_ill = w_chg && (w_d == 2'd2);

  always_comb begin
    w_acc_nx = r_acc;
    if (w_fwd) w_acc_nx = r_acc + 4'sd1;
    else if (w_rev) w_acc_nx = r_acc - 4'sd1;
  end

  assign w_emit_p = w_fwd && (w_acc_nx == EPC);
  assign w_emit_n = w_rev && (w_acc_nx == EMC);
  assign w_emit   = w_emit_p || w_emit_n;

  // Sync, filter and decode: advance on ce only
  always_ff @(posedge clk_12m or negedge reset) begin
    if (!reset) begin
      r_sync <= '1;
      r_cand <= 2'b11;
      r_filt <= 2'b11;
      r_prev <= 2'b11;
      r_fcnt <= '0;
      r_acc  <= '0;
    end else if (bus.ce) begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], bus.spinner};
      r_prev <= r_filt;
      if (w_sync != r_cand) begin
        r_cand <= w_sync;
        r_fcnt <= '0;
      end else if (r_cand != r_filt) begin
        if (r_fcnt == FL_M1) begin
          r_filt <= r_cand;
          r_fcnt <= '0;
        end else begin
          r_fcnt <= r_fcnt + 4'd1;
        end
      end
      if (w_emit) r_acc <= '0;
      else if (w_fwd || w_rev) r_acc <= w_acc_nx;
    end
  end

  // Pulses and CPU-visible state: act every clock
  always_ff @(posedge clk_12m or negedge reset) begin
    if (!reset) begin
      r_step    <= 1'b0;
      r_err     <= 1'b0;
      r_dir     <= 1'b0;
      r_pos     <= '0;
      r_delta   <= '0;
      r_rd_data <= '0;
      r_err_cnt <= '0;
    end else begin
      r_step <= w_emit;
      r_err  <= w_ill;
      if (w_emit) r_dir <= w_emit_p;
      if (bus.clear) begin
        r_pos     <= '0;
        r_delta   <= '0;
        r_err_cnt <= '0;
      end else begin
        if (w_emit_p) r_pos <= r_pos + 8'd1;
        else if (w_emit_n) r_pos <= r_pos - 8'd1;
        if (w_ill && r_err_cnt != 4'd15)
          r_err_cnt <= r_err_cnt + 4'd1;
        if (bus.rd) begin
          r_rd_data <= r_delta;
          // a count landing on the read starts the next delta
          if (w_emit_p) r_delta <= 8'sd1;
          else if (w_emit_n) r_delta <= -8'sd1;
          else r_delta <= '0;
        end else if (w_emit_p && r_delta != 8'sd127) begin
          r_delta <= r_delta + 8'sd1;
        end else if (w_emit_n && r_delta != -8'sd128) begin
          r_delta <= r_delta - 8'sd1;
        end
      end
    end
  end

  assign bus.step     = r_step;
  assign bus.err      = r_err;
  assign bus.dir      = r_dir;
  assign bus.position = r_pos;
  assign bus.rd_data  = r_rd_data;
  assign bus.err_cnt  = r_err_cnt;

endmodule

// File: tb/tb_spinner_quad_decoder.sv
// Directed bench for spinner_quad_decoder (EDGES_PER_COUNT 1 and 4 instances).
// Table vectors for level sequences, hand sequences for strobe corner cases.
module tb_spinner_quad_decoder;

  logic clk;
  logic rst_n;
  int   ncmp;
  int   nbad;

  spinner_quad_decoder_if ifa ();
  spinner_quad_decoder_if ifb ();

  spinner_quad_decoder #(
    .SYNC_STAGES(2), .FILTER_LEN(4), .EDGES_PER_COUNT(1)
  ) u_a (
    .clk_12m(clk), .reset(rst_n), .bus(ifa.slave)
  );

  spinner_quad_decoder #(
    .SYNC_STAGES(2), .FILTER_LEN(4), .EDGES_PER_COUNT(4)
  ) u_b (
    .clk_12m(clk), .reset(rst_n), .bus(ifb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] lvl;
    int hold;
    int steps;
    int lat;
    int dir;
    int errs;
    int pos;
    int ecnt;
  } vec_t;

  vec_t tv[11];

  task automatic chk(input string nm, input int act, input int exp);
    ncmp++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [1:0] fwd(input logic [1:0] v);
    case (v)
      2'b11:   fwd = 2'b01;
      2'b01:   fwd = 2'b00;
      2'b00:   fwd = 2'b10;
      default: fwd = 2'b11;
    endcase
  endfunction

  // Drive a level on one instance and watch it for hold cycles
  task automatic apply(input bit sel, input logic [1:0] lvl,
                       input int hold, output int nst,
                       output int lat, output int ldir,
                       output int nerr);
    if (sel) ifb.spinner = lvl;
    else ifa.spinner = lvl;
    nst = 0; lat = -1; ldir = -1; nerr = 0;
    for (int n = 1; n <= hold; n++) begin
      @(posedge clk); #1;
      if (sel ? ifb.step : ifa.step) begin
        nst++;
        if (lat < 0) lat = n - 1;
        ldir = int'(sel ? ifb.dir : ifa.dir);
      end
      if (sel ? ifb.err : ifa.err) nerr++;
    end
  endtask

  task automatic pulse_rd();
    ifa.rd = 1'b1;
    @(posedge clk); #1;
    ifa.rd = 1'b0;
  endtask

  // Next forward level on A with rd/clear landing on the emission edge
  task automatic emit_with(input logic [1:0] lvl, input bit do_rd,
                           input bit do_clr, output int st);
    ifa.spinner = lvl;
    repeat (7) @(posedge clk);
    #1;
    ifa.rd = do_rd;
    ifa.clear = do_clr;
    @(posedge clk); #1;
    st = int'(ifa.step);
    ifa.rd = 1'b0;
    ifa.clear = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] cur;
    logic [1:0] curb;
    int nst, lat, ldir, nerr, tot, totb, st;
    ncmp = 0; nbad = 0;

    tv[0]  = '{2'b01, 10, 1, 7, 1, 0, 1, 0};
    tv[1]  = '{2'b00, 10, 1, 7, 1, 0, 2, 0};
    tv[2]  = '{2'b10, 10, 1, 7, 1, 0, 3, 0};
    tv[3]  = '{2'b11, 10, 1, 7, 1, 0, 4, 0};
    tv[4]  = '{2'b10, 10, 1, 7, 0, 0, 3, 0};
    tv[5]  = '{2'b00, 10, 1, 7, 0, 0, 2, 0};
    tv[6]  = '{2'b01, 10, 1, 7, 0, 0, 1, 0};
    tv[7]  = '{2'b11, 10, 1, 7, 0, 0, 0, 0};
    tv[8]  = '{2'b01,  3, 0, 0, 0, 0, 0, 0};
    tv[9]  = '{2'b11, 10, 0, 0, 0, 0, 0, 0};
    tv[10] = '{2'b00, 10, 0, 0, 0, 1, 0, 1};

    rst_n = 1'b0;
    ifa.ce = 1'b1; ifa.spinner = 2'b11;
    ifa.clear = 1'b0; ifa.rd = 1'b0;
    ifb.ce = 1'b1; ifb.spinner = 2'b11;
    ifb.clear = 1'b0; ifb.rd = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pos", int'(ifa.position), 0);
    chk("rst_step", int'(ifa.step), 0);
    chk("rst_rd_data", int'(ifa.rd_data), 0);
    rst_n = 1'b1;

    apply(1'b0, 2'b11, 50, nst, lat, ldir, nerr);
    chk("idle_steps", nst, 0);
    chk("idle_errs", nerr, 0);
    chk("idle_pos", int'(ifa.position), 0);

    foreach (tv[i]) begin
      apply(1'b0, tv[i].lvl, tv[i].hold, nst, lat, ldir, nerr);
      chk($sformatf("v%0d_steps", i), nst, tv[i].steps);
      chk($sformatf("v%0d_errs", i), nerr, tv[i].errs);
      chk($sformatf("v%0d_pos", i), int'(ifa.position), tv[i].pos);
      chk($sformatf("v%0d_ecnt", i), int'(ifa.err_cnt), tv[i].ecnt);
      if (tv[i].steps > 0) begin
        chk($sformatf("v%0d_lat", i), lat, tv[i].lat);
        chk($sformatf("v%0d_dir", i), ldir, tv[i].dir);
      end
    end

    // 15 more illegal jumps; counter sticks at 15
    cur = 2'b00; tot = 0;
    for (int j = 0; j < 15; j++) begin
      cur = ~cur;
      apply(1'b0, cur, 10, nst, lat, ldir, nerr);
      tot += nerr;
    end
    chk("ill_pulses", tot, 15);
    chk("ill_sat", int'(ifa.err_cnt), 15);
    chk("ill_pos", int'(ifa.position), 0);

    pulse_rd();
    ifa.clear = 1'b1;
    @(posedge clk); #1;
    ifa.clear = 1'b0;
    chk("clr_ecnt", int'(ifa.err_cnt), 0);

    apply(1'b0, 2'b10, 10, nst, lat, ldir, nerr);
    chk("dec_wrap_pos", int'(ifa.position), 255);
    chk("dec_wrap_dir", ldir, 0);
    apply(1'b0, 2'b11, 10, nst, lat, ldir, nerr);
    chk("inc_wrap_pos", int'(ifa.position), 0);
    pulse_rd();
    chk("rd_after_wrap", int'(ifa.rd_data), 0);

    cur = 2'b11; tot = 0;
    for (int j = 0; j < 130; j++) begin
      cur = fwd(cur);
      apply(1'b0, cur, 8, nst, lat, ldir, nerr);
      tot += nst;
    end
    chk("inc130_steps", tot, 130);
    chk("inc130_pos", int'(ifa.position), 130);
    pulse_rd();
    chk("rd_sat", int'(ifa.rd_data), 127);
    pulse_rd();
    chk("rd_zeroed", int'(ifa.rd_data), 0);

    for (int j = 0; j < 5; j++) begin
      cur = fwd(cur);
      apply(1'b0, cur, 8, nst, lat, ldir, nerr);
    end
    cur = fwd(cur);
    emit_with(cur, 1'b1, 1'b0, st);
    chk("rdcoin_step", st, 1);
    chk("rdcoin_data", int'(ifa.rd_data), 5);
    chk("rdcoin_pos", int'(ifa.position), 136);
    pulse_rd();
    chk("rdcoin_kept", int'(ifa.rd_data), 1);

    for (int j = 0; j < 2; j++) begin
      cur = fwd(cur);
      apply(1'b0, cur, 8, nst, lat, ldir, nerr);
    end
    cur = fwd(cur);
    emit_with(cur, 1'b1, 1'b1, st);
    chk("clrcoin_step", st, 1);
    chk("clrcoin_pos", int'(ifa.position), 0);
    chk("clrcoin_rd_data", int'(ifa.rd_data), 1);
    pulse_rd();
    chk("clrcoin_delta", int'(ifa.rd_data), 0);

    // ce low freezes the pipeline
    ifa.ce = 1'b0;
    cur = fwd(cur);
    apply(1'b0, cur, 20, nst, lat, ldir, nerr);
    chk("ce0_steps", nst, 0);
    chk("ce0_pos", int'(ifa.position), 0);
    ifa.ce = 1'b1;
    apply(1'b0, cur, 10, nst, lat, ldir, nerr);
    chk("ce1_lat", lat, 7);
    chk("ce1_pos", int'(ifa.position), 1);

    // EDGES_PER_COUNT = 4
    curb = 2'b11; totb = 0;
    for (int j = 0; j < 3; j++) begin
      curb = fwd(curb);
      apply(1'b1, curb, 10, nst, lat, ldir, nerr);
      totb += nst;
    end
    curb = 2'b00;
    apply(1'b1, curb, 10, nst, lat, ldir, nerr);
    totb += nst;
    curb = 2'b01;
    apply(1'b1, curb, 10, nst, lat, ldir, nerr);
    totb += nst;
    curb = 2'b11;
    apply(1'b1, curb, 10, nst, lat, ldir, nerr);
    totb += nst;
    chk("e4_back_steps", totb, 0);
    for (int j = 0; j < 4; j++) begin
      curb = fwd(curb);
      apply(1'b1, curb, 10, nst, lat, ldir, nerr);
      totb += nst;
    end
    chk("e4_fwd_steps", totb, 1);
    chk("e4_pos", int'(ifb.position), 1);
    chk("e4_dir", int'(ifb.dir), 1);

    totb = 0;
    for (int j = 0; j < 2; j++) begin
      curb = fwd(curb);
      apply(1'b1, curb, 10, nst, lat, ldir, nerr);
      totb += nst;
    end
    chk("e4_partial", totb, 0);

    // reset mid-motion: asynchronous, partial edges discarded
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("arst_b_pos", int'(ifb.position), 0);
    chk("arst_b_dir", int'(ifb.dir), 0);
    chk("arst_a_pos", int'(ifa.position), 0);
    ifa.spinner = 2'b11;
    ifb.spinner = 2'b11;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    curb = 2'b11; totb = 0;
    for (int j = 0; j < 3; j++) begin
      curb = fwd(curb);
      apply(1'b1, curb, 10, nst, lat, ldir, nerr);
      totb += nst;
    end
    chk("e4_post_rst_3", totb, 0);
    curb = fwd(curb);
    apply(1'b1, curb, 10, nst, lat, ldir, nerr);
    chk("e4_post_rst_4", nst, 1);
    chk("e4_post_rst_pos", int'(ifb.position), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

endmodule
